// File: rtl/mc_control_fsm_v2.sv
`default_nettype none
// ------------------------------------------------------------------------
// mc_control_fsm_v2 : multicycle RV32I control FSM with a memory handshake and timeout,
//                     trap states and cycle/instret counters.  Rev 1.0
// ------------------------------------------------------------------------
module mc_control_fsm_v2 #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             alu_bcond,
   input  logic             mem_ready,
   input  logic             halt_req,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic             ALU_op_sig,
   output logic             IorD,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             PCWrite,
   output logic             PCWriteNotCond,
   output logic             PCSource,
   output logic             RegWrite,
   output logic [2:0]       state,
   output logic             halted,
   output logic             mem_error,
   output logic             illegal_inst,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX1  = 3'd2;
   localparam logic [2:0] S_EX2  = 3'd3;
   localparam logic [2:0] S_MEM  = 3'd4;
   localparam logic [2:0] S_WB   = 3'd5;
   localparam logic [2:0] S_HALT = 3'd6;
   localparam logic [2:0] S_ERR  = 3'd7;

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

   // The wait counter holds completed stall cycles, so the last allowed wait is one below the limit.
   localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [2:0]       state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             merr_q, merr_d;
   logic             ill_q, ill_d;
   logic             retire;
   logic             wait_hit;

   assign wait_hit = (wait_q == WAIT_LAST) && !mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IF;
         wait_q    <= 8'd0;
         cycle_q   <= '0;
         instret_q <= '0;
         merr_q    <= 1'b0;
         ill_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
         merr_q    <= merr_d;
         ill_q     <= ill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      merr_d  = merr_q;
      ill_d   = ill_q;
      case (state_q)
         S_IF: begin
            if (mem_ready) begin
               state_d = S_ID;
            end else if (wait_hit) begin
               state_d = S_ERR;
               merr_d  = 1'b1;
            end
         end
         S_ID: begin
            case (opcode)
               OP_JAL, OP_JALR: state_d = S_WB;
               OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_BRANCH: state_d = S_EX1;
               OP_SYSTEM: begin
                  if (halt_req) begin
                     state_d = S_HALT;
                  end else begin
                     state_d = S_IF;
                     retire  = 1'b1;
                  end
               end
               default: begin
                  state_d = S_ERR;
                  ill_d   = 1'b1;
               end
            endcase
         end
         S_EX1: begin
            if (opcode == OP_BRANCH && !alu_bcond) begin
               state_d = S_IF;
               retire  = 1'b1;
            end else begin
               state_d = S_EX2;
            end
         end
         S_EX2: begin
            case (opcode)
               OP_ARITH, OP_ARITH_IMM: state_d = S_WB;
               OP_LOAD, OP_STORE:      state_d = S_MEM;
               OP_BRANCH: begin
                  state_d = S_IF;
                  retire  = 1'b1;
               end
               default:                state_d = S_IF;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (opcode == OP_STORE) begin
                  state_d = S_IF;
                  retire  = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_hit) begin
               state_d = S_ERR;
               merr_d  = 1'b1;
            end
         end
         S_WB: begin
            state_d = S_IF;
            retire  = 1'b1;
         end
         default: state_d = state_q;
      endcase

      if (state_d != state_q) begin
         wait_d = 8'd0;
      end else if (!mem_ready && (state_q == S_IF || state_q == S_MEM)) begin
         wait_d = wait_q + 8'd1;
      end else begin
         wait_d = wait_q;
      end

      cycle_d   = (state_q == S_HALT || state_q == S_ERR) ? cycle_q : cycle_q + CNT_ONE;
      instret_d = retire ? instret_q + CNT_ONE : instret_q;
   end

   always_comb begin
      ALUSrcA        = 1'b0;
      ALUSrcB        = 2'b00;
      ALU_op_sig     = 1'b0;
      IorD           = 1'b0;
      IRWrite        = 1'b0;
      MemRead        = 1'b0;
      MemWrite       = 1'b0;
      MemtoReg       = 1'b0;
      PCWrite        = 1'b0;
      PCWriteNotCond = 1'b0;
      PCSource       = 1'b0;
      RegWrite       = 1'b0;
      case (state_q)
         S_IF: begin
            MemRead = 1'b1;
            IRWrite = mem_ready;
         end
         S_ID: begin
            ALUSrcB = 2'b01;
            PCWrite = (opcode == OP_SYSTEM) && !halt_req;
         end
         S_EX1: begin
            if (opcode == OP_BRANCH) begin
               ALUSrcA        = 1'b1;
               ALU_op_sig     = 1'b1;
               PCWriteNotCond = 1'b1;
               PCSource       = 1'b1;
            end
         end
         S_EX2: begin
            case (opcode)
               OP_ARITH: begin
                  ALUSrcA    = 1'b1;
                  ALU_op_sig = 1'b1;
               end
               OP_ARITH_IMM, OP_LOAD, OP_STORE: begin
                  ALUSrcA    = 1'b1;
                  ALUSrcB    = 2'b10;
                  ALU_op_sig = 1'b1;
               end
               OP_BRANCH: begin
                  ALUSrcB = 2'b10;
                  PCWrite = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            IorD = 1'b1;
            if (opcode == OP_LOAD) begin
               MemRead = 1'b1;
            end else if (opcode == OP_STORE) begin
               MemWrite = 1'b1;
               ALUSrcB  = 2'b01;
               PCWrite  = mem_ready;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            case (opcode)
               OP_ARITH, OP_ARITH_IMM: ALUSrcB = 2'b01;
               OP_LOAD: begin
                  ALUSrcB  = 2'b01;
                  MemtoReg = 1'b1;
               end
               OP_JAL:  ALUSrcB = 2'b10;
               OP_JALR: begin
                  ALUSrcA = 1'b1;
                  ALUSrcB = 2'b10;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign state        = state_q;
   assign halted       = (state_q == S_HALT);
   assign mem_error    = merr_q;
   assign illegal_inst = ill_q;
   assign cycle_cnt    = cycle_q;
   assign instret_cnt  = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm_v2.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_mc_control_fsm_v2 : randomized bench with an instruction-level reference model.  Rev 1.0
// ------------------------------------------------------------------------
module tb_mc_control_fsm_v2;

   localparam int ST_IF = 0, ST_ID = 1, ST_EX1 = 2, ST_EX2 = 3;
   localparam int ST_MEM = 4, ST_WB = 5, ST_HALT = 6, ST_ERR = 7;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_L    = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_SYS  = 7'b1110011;

   logic clk = 1'b0;
   logic reset, alu_bcond, mem_ready, halt_req;
   logic [6:0] opcode;

   logic        a_srca, a_ialu, a_iord, a_irw, a_mr, a_mw, a_m2r, a_pcw, a_pcwnc, a_pcs, a_rw;
   logic [1:0]  a_srcb;
   logic [2:0]  a_state;
   logic        a_halted, a_merr, a_ill;
   logic [31:0] a_cyc, a_inst;
   logic        b_srca, b_ialu, b_iord, b_irw, b_mr, b_mw, b_m2r, b_pcw, b_pcwnc, b_pcs, b_rw;
   logic [1:0]  b_srcb;
   logic [2:0]  b_state;
   logic        b_halted, b_merr, b_ill;
   logic [3:0]  b_cyc, b_inst;

   wire [12:0] a_ctrl = {a_srca, a_srcb, a_ialu, a_iord, a_irw, a_mr, a_mw, a_m2r, a_pcw, a_pcwnc, a_pcs, a_rw};
   wire [12:0] b_ctrl = {b_srca, b_srcb, b_ialu, b_iord, b_irw, b_mr, b_mw, b_m2r, b_pcw, b_pcwnc, b_pcs, b_rw};

   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_cycles;
   logic [31:0] m_inst;
   logic        m_merr, m_ill;

   always #5 clk = ~clk;

   mc_control_fsm_v2 #(.CNT_W(32), .MEM_TIMEOUT(15)) u_dut_a (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond), .mem_ready(mem_ready),
      .halt_req(halt_req), .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ALU_op_sig(a_ialu), .IorD(a_iord),
      .IRWrite(a_irw), .MemRead(a_mr), .MemWrite(a_mw), .MemtoReg(a_m2r), .PCWrite(a_pcw),
      .PCWriteNotCond(a_pcwnc), .PCSource(a_pcs), .RegWrite(a_rw), .state(a_state),
      .halted(a_halted), .mem_error(a_merr), .illegal_inst(a_ill), .cycle_cnt(a_cyc), .instret_cnt(a_inst)
   );

   mc_control_fsm_v2 #(.CNT_W(4), .MEM_TIMEOUT(15)) u_dut_b (
      .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond), .mem_ready(mem_ready),
      .halt_req(halt_req), .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ALU_op_sig(b_ialu), .IorD(b_iord),
      .IRWrite(b_irw), .MemRead(b_mr), .MemWrite(b_mw), .MemtoReg(b_m2r), .PCWrite(b_pcw),
      .PCWriteNotCond(b_pcwnc), .PCSource(b_pcs), .RegWrite(b_rw), .state(b_state),
      .halted(b_halted), .mem_error(b_merr), .illegal_inst(b_ill), .cycle_cnt(b_cyc), .instret_cnt(b_inst)
   );

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected control word for one cycle, straight from the per-state control table.
   function automatic logic [12:0] exp_ctrl(input int st, input logic [6:0] op, input logic rdy, input logic hreq);
      logic       a, aop, iord, irw, mr, mw, m2r, pcw, pcwnc, pcs, rw;
      logic [1:0] b;
      {a, b, aop, iord, irw, mr, mw, m2r, pcw, pcwnc, pcs, rw} = 13'd0;
      case (st)
         ST_IF: begin mr = 1'b1; irw = rdy; end
         ST_ID: begin b = 2'b01; pcw = (op == OP_SYS) && !hreq; end
         ST_EX1: if (op == OP_B) begin a = 1'b1; aop = 1'b1; pcwnc = 1'b1; pcs = 1'b1; end
         ST_EX2: begin
            if (op == OP_R) begin a = 1'b1; aop = 1'b1; end
            else if (op == OP_I || op == OP_L || op == OP_S) begin a = 1'b1; b = 2'b10; aop = 1'b1; end
            else if (op == OP_B) begin b = 2'b10; pcw = 1'b1; end
         end
         ST_MEM: begin
            iord = 1'b1;
            if (op == OP_L) mr = 1'b1;
            if (op == OP_S) begin mw = 1'b1; b = 2'b01; pcw = rdy; end
         end
         ST_WB: begin
            rw = 1'b1; pcw = 1'b1;
            if (op == OP_R || op == OP_I) b = 2'b01;
            else if (op == OP_L) begin b = 2'b01; m2r = 1'b1; end
            else if (op == OP_JAL) b = 2'b10;
            else if (op == OP_JALR) begin a = 1'b1; b = 2'b10; end
         end
         default: ;
      endcase
      return {a, b, aop, iord, irw, mr, mw, m2r, pcw, pcwnc, pcs, rw};
   endfunction

   // One clock cycle in the expected state; ret marks the retiring cycle.
   task automatic cyc(input int est, input logic rdy, input logic ret);
      logic [12:0] e;
      mem_ready = rdy;
      @(negedge clk);
      e = exp_ctrl(est, opcode, rdy, halt_req);
      checks += 11;
      if (a_state !== 3'(est)) begin failures++; $display("FAIL state t=%0t got=%0d exp=%0d", $time, a_state, est); end
      if (a_ctrl !== e) begin failures++; $display("FAIL ctrl t=%0t st=%0d got=%b exp=%b", $time, est, a_ctrl, e); end
      if (a_halted !== (est == ST_HALT)) begin failures++; $display("FAIL halted t=%0t got=%b", $time, a_halted); end
      if (a_merr !== m_merr) begin failures++; $display("FAIL mem_error t=%0t got=%b exp=%b", $time, a_merr, m_merr); end
      if (a_ill !== m_ill) begin failures++; $display("FAIL illegal_inst t=%0t got=%b exp=%b", $time, a_ill, m_ill); end
      if (a_cyc !== m_cycles) begin failures++; $display("FAIL cycle_cnt t=%0t got=%0d exp=%0d", $time, a_cyc, m_cycles); end
      if (a_inst !== m_inst) begin failures++; $display("FAIL instret_cnt t=%0t got=%0d exp=%0d", $time, a_inst, m_inst); end
      if (b_state !== 3'(est)) begin failures++; $display("FAIL state4 t=%0t got=%0d exp=%0d", $time, b_state, est); end
      if (b_ctrl !== e) begin failures++; $display("FAIL ctrl4 t=%0t got=%b exp=%b", $time, b_ctrl, e); end
      if (b_cyc !== m_cycles[3:0]) begin failures++; $display("FAIL cycle_cnt4 t=%0t got=%0d exp=%0d", $time, b_cyc, m_cycles[3:0]); end
      if (b_inst !== m_inst[3:0]) begin failures++; $display("FAIL instret_cnt4 t=%0t got=%0d exp=%0d", $time, b_inst, m_inst[3:0]); end
      @(posedge clk);
      #1;
      if (est != ST_HALT && est != ST_ERR) m_cycles++;
      if (ret) m_inst++;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      m_cycles = 0;
      m_inst   = 0;
      m_merr   = 1'b0;
      m_ill    = 1'b0;
   endtask

   // Walks one instruction through the cycle sequence its class dictates.
   task automatic run_instr(input logic [6:0] op, input int s_if, input int s_mem, input logic bc, input logic hreq);
      opcode = op; alu_bcond = bc; halt_req = hreq;
      for (int i = 0; i < s_if; i++) cyc(ST_IF, 1'b0, 1'b0);
      cyc(ST_IF, 1'b1, 1'b0);
      case (op)
         OP_R, OP_I: begin
            cyc(ST_ID, rb(), 1'b0); cyc(ST_EX1, rb(), 1'b0); cyc(ST_EX2, rb(), 1'b0); cyc(ST_WB, rb(), 1'b1);
         end
         OP_L, OP_S: begin
            cyc(ST_ID, rb(), 1'b0); cyc(ST_EX1, rb(), 1'b0); cyc(ST_EX2, rb(), 1'b0);
            for (int i = 0; i < s_mem; i++) cyc(ST_MEM, 1'b0, 1'b0);
            if (op == OP_L) begin cyc(ST_MEM, 1'b1, 1'b0); cyc(ST_WB, rb(), 1'b1); end
            else cyc(ST_MEM, 1'b1, 1'b1);
         end
         OP_B: begin
            cyc(ST_ID, rb(), 1'b0);
            if (bc) begin cyc(ST_EX1, rb(), 1'b0); cyc(ST_EX2, rb(), 1'b1); end
            else cyc(ST_EX1, rb(), 1'b1);
         end
         OP_JAL, OP_JALR: begin cyc(ST_ID, rb(), 1'b0); cyc(ST_WB, rb(), 1'b1); end
         OP_SYS: cyc(ST_ID, rb(), !hreq);
         default: begin cyc(ST_ID, rb(), 1'b0); m_ill = 1'b1; end
      endcase
   endtask

   task automatic run_random_legal();
      logic [6:0] ops [8];
      logic [6:0] op;
      ops = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR, OP_SYS};
      op = ops[$urandom_range(0, 7)];
      run_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), rb(), (op == OP_SYS) ? 1'b0 : rb());
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks += 5;
      if (a_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", a_state); end
      if (a_ctrl !== 13'h040) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", a_ctrl, 13'h040); end
      if (a_cyc !== 32'd0 || a_inst !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_cyc, a_inst); end
      if ({a_halted, a_merr, a_ill} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {a_halted, a_merr, a_ill}); end
      if (b_cyc !== 4'd0 || b_inst !== 4'd0) begin failures++; $display("FAIL reset_cnt4 got=%0d/%0d exp=0/0", b_cyc, b_inst); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_add();
      do_reset();
      run_instr(OP_R, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      checks += 2;
      if (a_state !== 3'd0) begin failures++; $display("FAIL add_reentry got=%0d exp=0", a_state); end
      if (a_cyc !== 32'd5 || a_inst !== 32'd1) begin failures++; $display("FAIL add_counts got=%0d/%0d exp=5/1", a_cyc, a_inst); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_load_stall();
      do_reset();
      run_instr(OP_L, 0, 3, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (a_cyc !== 32'd9 || a_inst !== 32'd1) begin failures++; $display("FAIL lw_counts got=%0d/%0d exp=9/1", a_cyc, a_inst); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_branch();
      do_reset();
      run_instr(OP_B, $urandom_range(0, 3), 0, 1'b0, 1'b0);
      run_instr(OP_B, $urandom_range(0, 3), 0, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (a_inst !== 32'd2) begin failures++; $display("FAIL branch_retire got=%0d exp=2", a_inst); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_timeout();
      do_reset();
      opcode = OP_R; halt_req = 1'b0;
      for (int i = 0; i < 15; i++) cyc(ST_IF, 1'b0, 1'b0);
      m_merr = 1'b1;
      repeat (3) cyc(ST_ERR, rb(), 1'b0);
      checks++;
      if (a_cyc !== 32'd15 || a_merr !== 1'b1) begin failures++; $display("FAIL if_timeout got=%0d/%b exp=15/1", a_cyc, a_merr); end
      do_reset();
      run_instr(OP_R, 14, 0, 1'b0, 1'b0);
      do_reset();
      opcode = OP_S;
      cyc(ST_IF, 1'b1, 1'b0); cyc(ST_ID, rb(), 1'b0); cyc(ST_EX1, rb(), 1'b0); cyc(ST_EX2, rb(), 1'b0);
      for (int i = 0; i < 15; i++) cyc(ST_MEM, 1'b0, 1'b0);
      m_merr = 1'b1;
      repeat (2) cyc(ST_ERR, rb(), 1'b0);
   endtask

   task automatic test_illegal();
      do_reset();
      run_instr(7'b0000000, 1, 0, 1'b0, 1'b0);
      repeat (3) cyc(ST_ERR, rb(), 1'b0);
      checks++;
      if (a_ill !== 1'b1 || a_merr !== 1'b0) begin failures++; $display("FAIL illegal_flags got=%b/%b exp=1/0", a_ill, a_merr); end
   endtask

   task automatic test_halt();
      do_reset();
      run_instr(OP_I, 0, 0, 1'b0, 1'b0);
      run_instr(OP_SYS, 0, 0, 1'b0, 1'b1);
      repeat (3) cyc(ST_HALT, rb(), 1'b0);
      checks++;
      if (a_halted !== 1'b1 || a_inst !== 32'd1) begin failures++; $display("FAIL halt got=%b/%0d exp=1/1", a_halted, a_inst); end
   endtask

   task automatic test_reset_store();
      do_reset();
      run_instr(OP_R, 0, 0, 1'b0, 1'b0);
      opcode = OP_S;
      cyc(ST_IF, 1'b1, 1'b0); cyc(ST_ID, rb(), 1'b0); cyc(ST_EX1, rb(), 1'b0); cyc(ST_EX2, rb(), 1'b0);
      cyc(ST_MEM, 1'b0, 1'b0); cyc(ST_MEM, 1'b0, 1'b0);
      do_reset();
      @(negedge clk);
      checks += 2;
      if (a_state !== 3'd0 || a_mw !== 1'b0) begin failures++; $display("FAIL rst_store got=%0d/%b exp=0/0", a_state, a_mw); end
      if (a_cyc !== 32'd0 || a_inst !== 32'd0) begin failures++; $display("FAIL rst_store_cnt got=%0d/%0d exp=0/0", a_cyc, a_inst); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_wrap();
      do_reset();
      repeat (16) run_random_legal();
      checks++;
      if (b_inst !== 4'd0 || a_inst !== 32'd16) begin failures++; $display("FAIL wrap got=%0d/%0d exp=0/16", b_inst, a_inst); end
   endtask

   task automatic test_random();
      do_reset();
      repeat (40) run_random_legal();
   endtask

   initial begin
      reset = 1'b1; opcode = 7'd0; alu_bcond = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
      m_cycles = 0; m_inst = 0; m_merr = 1'b0; m_ill = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_add();
      test_load_stall();
      test_branch();
      test_timeout();
      test_illegal();
      test_halt();
      test_reset_store();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
